// File: rtl/ps2_key_event_decoder.sv
// PS/2 keyboard receiver and key event decoder.
// Synchronizes and deglitches the raw PS/2 pins, assembles 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and turns make/break/E0
// sequences into a key-held map, a last-changed code and a command code.
module ps2_key_event_decoder #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [8:0]  LEFT_CODE      = 9'h16B,
  parameter logic [8:0]  RIGHT_CODE     = 9'h174
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         been_ready,
  output logic [3:0]   key_num,
  output logic         frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // Synchronizer stages
  logic          clk_s1, clk_s2;
  logic          data_s1, data_s2;

  // Glitch filter and edge detect
  logic          filt_level;
  logic          filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  // Frame assembly
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          stop_fall;
  logic          frame_ok;

  // Byte decode
  logic          ext;
  logic          brk;
  logic [8:0]    code;
  logic [3:0]    code_key_num;

  // Two-flop synchronizers for both asynchronous pins
  always_ff @(posedge clk) begin
    clk_s1  <= ps2_clk;
    clk_s2  <= clk_s1;
    data_s1 <= ps2_data;
    data_s2 <= data_s1;
  end

  // Accept a new ps2_clk level only after FILTER_LEN equal consecutive samples.
  // Reset loads the current pin level so a reset while the line is low
  // does not manufacture a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_level <= clk_s2;
      filt_cnt   <= '0;
    end else if (clk_s2 == filt_level) begin
      filt_cnt   <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_level <= clk_s2;
      filt_cnt   <= '0;
    end else begin
      filt_cnt   <= filt_cnt + 1'b1;
    end
  end

  // Delayed filtered level for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) filt_prev <= clk_s2;
    else     filt_prev <= filt_level;
  end

  // Frame-level qualifiers
  always_comb begin
    fall        = filt_prev & ~filt_level;
    timeout_hit = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    stop_fall   = fall && (state == S_STOP);
    frame_ok    = data_s2 && (^{shreg, parity});
  end

  // Inter-edge watchdog: restarts on every edge, runs only inside a frame
  always_ff @(posedge clk) begin
    if (rst)                  to_cnt <= '0;
    else if (fall)            to_cnt <= '0;
    else if (timeout_hit)     to_cnt <= '0;
    else if (state != S_IDLE) to_cnt <= to_cnt + 1'b1;
    else                      to_cnt <= '0;
  end

  // Frame assembly FSM, advanced on filtered falling edges
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!data_s2) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          shreg   <= {data_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= S_PARITY;
        end
        S_PARITY: begin
          parity <= data_s2;
          state  <= S_STOP;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      state <= S_IDLE;
    end
  end

  // Code formation and arrow-key mapping
  always_comb begin
    code = {ext, shreg};
    if (code == LEFT_CODE)       code_key_num = 4'd2;
    else if (code == RIGHT_CODE) code_key_num = 4'd3;
    else                         code_key_num = 4'd4;
  end

  // Byte decode: prefixes arm ext/brk, any other byte commits an event.
  // Errors drop any pending prefix so a lost frame cannot mis-tag the next key.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_down    <= '0;
      last_change <= '0;
      key_num     <= 4'd4;
      been_ready  <= 1'b0;
      frame_err   <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
    end else begin
      been_ready <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout_hit || (stop_fall && !frame_ok)) begin
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else if (stop_fall) begin
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          key_down[code] <= ~brk;
          last_change    <= code;
          key_num        <= code_key_num;
          been_ready     <= 1'b1;
          ext            <= 1'b0;
          brk            <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder: directed PS/2 frames, expected
// events queued at issue time, a monitor pops one entry per output pulse.
module tb_ps2_key_event_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         ps2_clk;
  logic         ps2_data;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         been_ready;
  logic [3:0]   key_num;
  logic         frame_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    bit           is_err;
    logic [8:0]   lc;
    logic [3:0]   kn;
    logic [511:0] kd;
    string        name;
  } exp_t;

  exp_t         q[$];
  logic [511:0] m_kd = '0;
  logic [8:0]   m_lc = '0;
  logic [3:0]   m_kn = 4'd4;

  ps2_key_event_decoder #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (50),
    .LEFT_CODE      (9'h16B),
    .RIGHT_CODE     (9'h174)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_down    (key_down),
    .last_change (last_change),
    .been_ready  (been_ready),
    .key_num     (key_num),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [511:0] act, logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Expected key event with hand-computed code, key_num and held state
  task automatic expect_ready(input string name, input logic [8:0] lc,
                              input logic [3:0] kn, input bit held);
    exp_t e;
    m_kd[lc] = held;
    m_lc     = lc;
    m_kn     = kn;
    e.is_err = 1'b0;
    e.lc     = lc;
    e.kn     = kn;
    e.kd     = m_kd;
    e.name   = name;
    q.push_back(e);
  endtask

  task automatic expect_err(input string name);
    exp_t e;
    e.is_err = 1'b1;
    e.lc     = m_lc;
    e.kn     = m_kn;
    e.kd     = m_kd;
    e.name   = name;
    q.push_back(e);
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clks(5);
    ps2_clk = 1'b0;
    wait_clks(10);
    ps2_clk = 1'b1;
    wait_clks(5);
  endtask

  // Sends the first nbits bits of a frame (11 = complete frame)
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int unsigned nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    wait_clks(20);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 512'(q.size()), 512'd0);
    q.delete();
  endtask

  // Monitor: every output pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (been_ready || frame_err)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {510'd0, frame_err, been_ready}, 512'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_err"},   512'(frame_err),   512'(e.is_err));
        check({e.name, "_ready"}, 512'(been_ready),  512'(!e.is_err));
        check({e.name, "_lc"},    512'(last_change), 512'(e.lc));
        check({e.name, "_kn"},    512'(key_num),     512'(e.kn));
        check({e.name, "_kd"},    key_down,          e.kd);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b;
    logic [10:0] f;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(6);
    check("rst_kd", key_down, 512'd0);
    check("rst_lc", 512'(last_change), 512'd0);
    check("rst_kn", 512'(key_num), 512'd4);
    check("rst_rdy_err", 512'({been_ready, frame_err}), 512'd0);
    rst = 1'b0;
    wait_clks(10);

    // A make
    expect_ready("a_make", 9'h01C, 4'd4, 1'b1);
    send_frame(8'h1C, 1'b0, 11);
    drain("drain_a_make");

    // Extended left arrow make, then break
    send_frame(8'hE0, 1'b0, 11);
    expect_ready("left_make", 9'h16B, 4'd2, 1'b1);
    send_frame(8'h6B, 1'b0, 11);
    drain("drain_left_make");
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    expect_ready("left_break", 9'h16B, 4'd2, 1'b0);
    send_frame(8'h6B, 1'b0, 11);
    drain("drain_left_break");

    // Bad parity, then extended right arrow
    expect_err("bad_parity");
    send_frame(8'h74, 1'b1, 11);
    drain("drain_bad_parity");
    send_frame(8'hE0, 1'b0, 11);
    expect_ready("right_make", 9'h174, 4'd3, 1'b1);
    send_frame(8'h74, 1'b0, 11);
    drain("drain_right");

    // E0 then a truncated frame: timeout must also drop the pending E0
    send_frame(8'hE0, 1'b0, 11);
    expect_err("timeout");
    send_frame(8'h1C, 1'b0, 5);
    wait_clks(60);
    drain("drain_timeout");
    expect_ready("a_repeat", 9'h01C, 4'd4, 1'b1);
    send_frame(8'h1C, 1'b0, 11);
    drain("drain_a_repeat");

    // Break of a key never pressed
    send_frame(8'hF0, 1'b0, 11);
    expect_ready("q_break_unheld", 9'h015, 4'd4, 1'b0);
    send_frame(8'h15, 1'b0, 11);
    drain("drain_q_break");

    // Short ps2_clk low glitch with data low must not start a frame
    ps2_data = 1'b0;
    wait_clks(3);
    ps2_clk = 1'b0;
    wait_clks(2);
    ps2_clk = 1'b1;
    wait_clks(20);
    ps2_data = 1'b1;
    wait_clks(20);
    expect_ready("s_after_glitch", 9'h01B, 4'd4, 1'b1);
    send_frame(8'h1B, 1'b0, 11);
    drain("drain_glitch");

    // Reset during the parity bit of a 0x1C frame
    b = 8'h1C;
    f = {1'b1, ~^b, b, 1'b0};
    for (int unsigned i = 0; i < 9; i++) send_bit(f[i]);
    ps2_data = f[9];
    wait_clks(5);
    ps2_clk = 1'b0;
    wait_clks(9);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_kd", key_down, 512'd0);
    check("midrst_lc", 512'(last_change), 512'd0);
    check("midrst_kn", 512'(key_num), 512'd4);
    check("midrst_rdy_err", 512'({been_ready, frame_err}), 512'd0);
    rst  = 1'b0;
    m_kd = '0;
    m_lc = '0;
    m_kn = 4'd4;
    wait_clks(3);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(80);
    expect_ready("a_after_rst", 9'h01C, 4'd4, 1'b1);
    send_frame(8'h1C, 1'b0, 11);
    drain("drain_after_rst");

    wait_clks(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
